// File: rtl/systolic_drain_pkg.sv
// Shared types and helpers for the systolic array result drain.
package systolic_drain_pkg;

  // Constants for the default configuration (D_W = 8, N = 2).
  localparam int DEF_D_W = 8;
  localparam int DEF_N   = 2;
  localparam int RES_W   = 2 * DEF_D_W;
  localparam int IDX_W   = ((DEF_N * DEF_N) > 1) ? $clog2(DEF_N * DEF_N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cycles from the start edge to the edge that samples z_flat:
  // k_len operand pairs plus the 2*n-1 cycle skew through the array.
  function automatic int settle_cycles(input int k_len, input int n);
    return k_len + 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_drain.sv
// Result reader for the N x N systolic MAC array: waits for the array to
// settle, snapshots z_flat, pulses acc_clr and streams the N*N results
// row-major over a valid/ready interface.
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 2,
  parameter int KW  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [KW-1:0]                       k_len,
  input  logic [N*N*2*D_W-1:0]                z_flat,
  output logic                                acc_clr,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [2*D_W-1:0]                    m_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_row,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_col,
  output logic                                m_last,
  output logic                                busy,
  output logic                                err_overrun
);

  localparam int RW  = 2 * D_W;
  localparam int NN  = N * N;
  localparam int IW  = sel_width(NN);
  localparam int RCW = sel_width(N);
  // Wide enough for the largest k_len plus the 2N-1 skew.
  localparam int CW  = KW + $clog2(2 * N) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              clr_q, clr_d;
  logic              ovr_q, ovr_d;
  logic [NN*RW-1:0]  snap_q, snap_d;

  logic [CW-1:0]     load_val;
  logic              xfer;

  assign load_val = CW'(settle_cycles(int'(k_len), N));
  assign xfer     = m_valid & m_ready;

  // State, counter, index and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      ovr_q   <= ovr_d;
      snap_q  <= snap_d;
    end
  end

  // Next-state logic: settle countdown, one-cycle capture, handshake drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    clr_d   = 1'b0;
    snap_d  = snap_q;
    // A start that is not taken from IDLE is an overrun; it stays flagged.
    ovr_d   = ovr_q | (start & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = load_val;
          // A one-cycle settle time means the very next edge must sample.
          state_d = (load_val == CW'(1)) ? CAPTURE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // Enter CAPTURE as the count reaches 1 so the capture edge lands
        // exactly settle_cycles edges after the start edge.
        if (cnt_q <= CW'(2)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        snap_d  = z_flat;
        cnt_d   = '0;
        idx_d   = '0;
        clr_d   = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid     = (state_q == STREAM);
  assign acc_clr     = clr_q;
  assign busy        = (state_q != IDLE);
  assign err_overrun = ovr_q;
  // Outputs depend only on registered state, so they hold while stalled.
  assign m_data      = m_valid ? snap_q[int'(idx_q)*RW +: RW] : '0;
  assign m_row       = m_valid ? RCW'(int'(idx_q) / N) : '0;
  assign m_col       = m_valid ? RCW'(int'(idx_q) % N) : '0;
  assign m_last      = m_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized self-checking bench for systolic_drain.
module tb_systolic_drain;

  localparam int D_W = 8;
  localparam int N   = 2;
  localparam int KW  = 8;
  localparam int NN  = N * N;
  localparam int RW  = 2 * D_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic [NN*RW-1:0]  z_flat;
  logic              acc_clr;
  logic              m_valid;
  logic              m_ready;
  logic [RW-1:0]     m_data;
  logic [0:0]        m_row;
  logic [0:0]        m_col;
  logic              m_last;
  logic              busy;
  logic              err_overrun;

  int   checks = 0;
  int   errors = 0;
  logic ovr_exp;

  systolic_drain #(.D_W(D_W), .N(N), .KW(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .z_flat     (z_flat),
    .acc_clr    (acc_clr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_col      (m_col),
    .m_last     (m_last),
    .busy       (busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),    32'd0);
    check({tag, "_clr"},   32'(acc_clr), 32'd0);
    check({tag, "_data"},  32'(m_data),  32'd0);
    check({tag, "_row"},   32'(m_row),   32'd0);
    check({tag, "_col"},   32'(m_col),   32'd0);
    check({tag, "_last"},  32'(m_last),  32'd0);
    check({tag, "_ovr"},   32'(err_overrun), 32'd0);
  endtask

  function automatic logic [NN*RW-1:0] rand_flat();
    logic [NN*RW-1:0] v;
    for (int e = 0; e < NN; e++) v[e*RW +: RW] = RW'($urandom);
    return v;
  endfunction

  // One tile. The model: the word stream equals the z_flat value that was
  // present at the edge k+2N-1 edges after the start edge, in row-major
  // order, first word visible right after that edge; each accepted word
  // advances the stream by one.
  task automatic run_tile(input int k, input int ready_mode, input bit ovr_wait,
                          input bit ovr_last, input int abort_at, input bit fixed_tile);
    logic [RW-1:0]    tile [NN];
    logic [NN*RW-1:0] tile_flat;
    int  kk   = k + 2 * N - 1;
    int  j    = 0;
    bit  done = 0;
    for (int e = 0; e < NN; e++) begin
      tile[e] = fixed_tile ? RW'(16'h0011 * (e + 1)) : RW'($urandom);
      tile_flat[e*RW +: RW] = tile[e];
    end
    start   = 1'b1;
    k_len   = KW'(k);
    z_flat  = rand_flat();
    m_ready = 1'($urandom);
    for (int i = 0; i < kk + 100 && !done; i++) begin
      @(posedge clk);
      #1;
      check("overrun", 32'(err_overrun), 32'(ovr_exp));
      if (i < kk) begin
        check("wait_busy",  32'(busy),    32'd1);
        check("wait_valid", 32'(m_valid), 32'd0);
        check("wait_clr",   32'(acc_clr), 32'd0);
      end else if (j < NN) begin
        check("valid", 32'(m_valid), 32'd1);
        check("busy",  32'(busy),    32'd1);
        check("clr",   32'(acc_clr), 32'(i == kk));
        check("data",  32'(m_data),  32'(tile[j]));
        check("row",   32'(m_row),   32'(j / N));
        check("col",   32'(m_col),   32'(j % N));
        check("last",  32'(m_last),  32'(j == NN - 1));
      end else begin
        check("end_valid", 32'(m_valid), 32'd0);
        check("end_busy",  32'(busy),    32'd0);
        check("end_clr",   32'(acc_clr), 32'd0);
        done = 1;
      end

      if (abort_at >= 0 && i >= kk && j == abort_at) begin
        start = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("rst_now");
        ovr_exp = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(posedge clk);
          #1;
          check("post_rst_valid", 32'(m_valid), 32'd0);
          check("post_rst_clr",   32'(acc_clr), 32'd0);
          check("post_rst_busy",  32'(busy),    32'd0);
        end
        return;
      end

      // Drive inputs for the next edge.
      start = 1'b0;
      k_len = KW'($urandom);
      if (ovr_wait && i == 1) begin
        start   = 1'b1;
        ovr_exp = 1'b1;
      end
      if (i + 1 < kk)       z_flat = rand_flat();
      else if (i + 1 == kk) z_flat = tile_flat;
      else                  z_flat = {NN{16'hFFFF}};
      if (i < kk) m_ready = 1'($urandom);
      else begin
        case (ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = 1'($urandom);
          default: m_ready = ((i - kk) < 3) ? 1'b0 : 1'b1;
        endcase
      end
      if (i >= kk && j < NN && m_ready) begin
        if (ovr_last && j == NN - 1) begin
          start   = 1'b1;
          ovr_exp = 1'b1;
        end
        j++;
      end
    end
    start = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    k_len   = '0;
    z_flat  = '0;
    ovr_exp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check_all_zero("reset");
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("idle_busy",  32'(busy),    32'd0);
      check("idle_valid", 32'(m_valid), 32'd0);
    end

    run_tile(3, 0, 0, 0, -1, 1);     // basic drain
    run_tile(3, 2, 0, 0, -1, 1);     // backpressure on first word
    run_tile(3, 0, 1, 1, -1, 1);     // overrun in WAIT and on final transfer
    run_tile(5, 1, 0, 0, -1, 0);     // normal tile after overrun
    run_tile(0, 0, 0, 0, -1, 1);     // zero-length tile
    run_tile(255, 1, 0, 0, -1, 0);   // maximum k_len
    run_tile(3, 0, 0, 0, 2, 1);      // reset after two words
    run_tile(3, 0, 0, 0, -1, 1);     // full tile after reset
    for (int t = 0; t < 8; t++) begin
      run_tile($urandom_range(0, 20), 1, 0, 0, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
